// File: rtl/truth_table_sweeper_if.sv
// Handshake and stimulus/capture signals between the sweeper and its user.
// The slave side is the sweeper itself; the master side drives start and
// returns the circuit output y_in.
interface truth_table_sweeper_if;
  logic       start;
  logic       y_in;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       sample_valid;
  logic       done;
  logic [7:0] truth_table;

  modport slave (
    input  start, y_in,
    output a, b, c, busy, sample_valid, done, truth_table
  );

  modport master (
    output start, y_in,
    input  a, b, c, busy, sample_valid, done, truth_table
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Self-timed sequencer that walks {a,b,c} through 000..111, holds each
// combination for DWELL clocks, captures y_in on the last dwell cycle and
// assembles the 8-bit truth table of the circuit under sweep.
module truth_table_sweeper #(
  parameter int DWELL = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  truth_table_sweeper_if.slave    bus
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state;
  logic [2:0]       index;
  logic [CNT_W-1:0] dwell_cnt;
  logic [2:0]       stim;
  logic             busy_q;
  logic             sample_valid_q;
  logic             done_q;
  logic [7:0]       table_q;

  // Sweep sequencer: every output is a register updated here, so the
  // circuit under sweep always sees clean, glitch-free stimulus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      index          <= 3'd0;
      dwell_cnt      <= '0;
      stim           <= 3'd0;
      busy_q         <= 1'b0;
      sample_valid_q <= 1'b0;
      done_q         <= 1'b0;
      table_q        <= 8'h00;
    end else begin
      sample_valid_q <= 1'b0;
      done_q         <= 1'b0;
      case (state)
        ST_IDLE: begin
          stim   <= 3'd0;
          busy_q <= 1'b0;
          if (bus.start) begin
            state     <= ST_DRIVE;
            index     <= 3'd0;
            dwell_cnt <= '0;
            table_q   <= 8'h00;
            busy_q    <= 1'b1;
          end
        end
        ST_DRIVE: begin
          if (dwell_cnt == DWELL_LAST) begin
            table_q[index] <= bus.y_in;
            sample_valid_q <= 1'b1;
            dwell_cnt      <= '0;
            if (index == 3'd7) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
              busy_q <= 1'b0;
              stim   <= 3'd0;
            end else begin
              index <= index + 3'd1;
              stim  <= index + 3'd1;
            end
          end else begin
            dwell_cnt <= dwell_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          stim   <= 3'd0;
        end
      endcase
    end
  end

  assign bus.a            = stim[2];
  assign bus.b            = stim[1];
  assign bus.c            = stim[0];
  assign bus.busy         = busy_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.done         = done_q;
  assign bus.truth_table  = table_q;

endmodule
